// File: rtl/pulse_conditioner_pkg.sv
// Shared definitions for the pulse conditioner.
//   mode_e     : edge-select encodings seen on the MODE port.
//   cnt_width  : bit width of a counter that must hold values 0..max_val.
package pulse_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    // A counter for 0..max_val needs $clog2(max_val+1) bits; never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_cond_ch.sv
// One pulse-conditioner channel: synchroniser chain, debounce filter,
// mode-qualified edge detect and one-shot pulse counter.
// Ports:
//   CLK      in  system clock, rising edge
//   RST      in  asynchronous active-high reset
//   EN       in  pulse enable; 0 clears the pulse counter
//   MODE     in  edge select (mode_e)
//   l_in     in  normalised, still asynchronous level
//   p_out    out registered one-shot pulse
//   lvl_out  out registered debounced level
//   busy_out out high while the pulse counter is non-zero
module pulse_cond_ch
    import pulse_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int PULSE_LEN   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] MODE,
    input  logic       l_in,
    output logic       p_out,
    output logic       lvl_out,
    output logic       busy_out
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int PW = cnt_width(PULSE_LEN);
    // Value the debounce counter holds on the cycle the level is accepted.
    localparam logic [DW-1:0] DEB_TOP   = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_TOP = PW'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic                   lvl_q, lvl_d;
    logic                   active_q, active_d;
    logic                   s_lvl;
    logic                   toggle;
    logic                   edge_ev;

    assign s_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], l_in};
        lvl_d     = lvl_q;
        deb_cnt_d = '0;
        toggle    = 1'b0;
        // Any cycle where s matches LVL wipes the count: no partial credit.
        if (s_lvl != lvl_q) begin
            if (deb_cnt_q == DEB_TOP) begin
                toggle = 1'b1;
                lvl_d  = ~lvl_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Direction is judged from the level before the toggle.
    always_comb begin
        edge_ev = 1'b0;
        case (mode_e'(MODE))
            MODE_RISE: edge_ev = toggle & ~lvl_q;
            MODE_FALL: edge_ev = toggle &  lvl_q;
            MODE_BOTH: edge_ev = toggle;
            default:   edge_ev = 1'b0;
        endcase
    end

    // Events arriving while a pulse runs are dropped, not queued or extended.
    always_comb begin
        pcnt_d = '0;
        if (!EN) begin
            pcnt_d = '0;
        end else if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - 1'b1;
        end else if (edge_ev) begin
            pcnt_d = PULSE_TOP;
        end
        active_d = (pcnt_d != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            lvl_q     <= 1'b0;
            pcnt_q    <= '0;
            active_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
            pcnt_q    <= pcnt_d;
            active_q  <= active_d;
        end
    end

    assign p_out    = active_q;
    assign busy_out = active_q;
    assign lvl_out  = lvl_q;

endmodule

// File: rtl/pulse_conditioner.sv
// Multi-channel level-to-pulse converter for buttons and switches.
// Each channel is an independent pulse_cond_ch; this level only applies
// the input polarity.
// Ports:
//   CLK  in  system clock, rising edge
//   RST  in  asynchronous active-high reset
//   EN   in  global enable; 0 forces P low and aborts running pulses
//   MODE in  edge select: 00 rise, 01 fall, 10 both, 11 off
//   L    in  raw asynchronous levels, N_CH wide
//   P    out registered one-shot pulses
//   LVL  out registered debounced, normalised levels
//   BUSY out per-channel pulse-in-progress flags
module pulse_conditioner
    import pulse_conditioner_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int PULSE_LEN   = 1,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [1:0]      MODE,
    input  logic [N_CH-1:0] L,
    output logic [N_CH-1:0] P,
    output logic [N_CH-1:0] LVL,
    output logic [N_CH-1:0] BUSY
);

    // Inverting active-low pins makes "pressed" read as 1 inside every channel.
    localparam logic [N_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0] l_norm;

    assign l_norm = L ^ POL_MASK;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            pulse_cond_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES),
                .PULSE_LEN   (PULSE_LEN)
            ) u_ch (
                .CLK      (CLK),
                .RST      (RST),
                .EN       (EN),
                .MODE     (MODE),
                .l_in     (l_norm[gi]),
                .p_out    (P[gi]),
                .lvl_out  (LVL[gi]),
                .busy_out (BUSY[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner. Five instances with different
// parameter sets share clock, reset, enable and mode; each scenario drives
// only its own instance's L input. All actions and samples happen on the
// falling clock edge, so "after edge k" means k rising edges after the
// negedge on which the input changed.
module tb_pulse_conditioner;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] l_a, l_b, l_c, l_d, l_e;
    logic [3:0] p_a, p_b, p_c, p_d, p_e;
    logic [3:0] lvl_a, lvl_b, lvl_c, lvl_d, lvl_e;
    logic [3:0] busy_a, busy_b, busy_c, busy_d, busy_e;

    int checks = 0;
    int errors = 0;

    // defaults
    pulse_conditioner dut_a (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .L(l_a),
        .P(p_a), .LVL(lvl_a), .BUSY(busy_a));

    pulse_conditioner #(.PULSE_LEN(3)) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .L(l_b),
        .P(p_b), .LVL(lvl_b), .BUSY(busy_b));

    pulse_conditioner #(.PULSE_LEN(8), .DEB_CYCLES(1)) dut_c (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .L(l_c),
        .P(p_c), .LVL(lvl_c), .BUSY(busy_c));

    pulse_conditioner #(.ACTIVE_LOW(1)) dut_d (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .L(l_d),
        .P(p_d), .LVL(lvl_d), .BUSY(busy_d));

    pulse_conditioner #(.PULSE_LEN(5)) dut_e (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .L(l_e),
        .P(p_e), .LVL(lvl_e), .BUSY(busy_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int pulses, hi, first_k, lvl_chg;
    logic prev_p, prev_lvl;
    int exp_pulses [4] = '{1, 1, 2, 0};
    int exp_hi     [4] = '{3, 3, 6, 0};
    int exp_first  [4] = '{6, 16, 6, 0};

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        mode = 2'b00;
        l_a  = 4'hF;
        l_b  = 4'h0;
        l_c  = 4'h0;
        l_d  = 4'hF;
        l_e  = 4'h0;
        #1 rst = 1'b1;

        // 1: reset with all inputs high, then 6-edge latency to LVL and P
        cyc();
        check("rst_p", {28'd0, p_a}, 32'h0);
        check("rst_lvl", {28'd0, lvl_a}, 32'h0);
        cyc();
        cyc();
        check("rst_lvl_late", {28'd0, lvl_a}, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 5) begin
                check("t1_lvl_e5", {28'd0, lvl_a}, 32'h0);
                check("t1_p_e5", {28'd0, p_a}, 32'h0);
            end
            if (k == 6) begin
                check("t1_lvl_e6", {28'd0, lvl_a}, 32'hF);
                check("t1_p_e6", {28'd0, p_a}, 32'hF);
                check("t1_busy_e6", {28'd0, busy_a}, 32'hF);
            end
            if (k == 7) check("t1_p_e7", {28'd0, p_a}, 32'h0);
        end

        // 2: bounce on channel 0, then a steady hold
        l_a = 4'h0;
        repeat (10) cyc();
        check("t2_lvl_low", {28'd0, lvl_a}, 32'h0);
        check("t2_p_low", {28'd0, p_a}, 32'h0);
        pulses = 0; first_k = 0; lvl_chg = 0;
        prev_p = 1'b0; prev_lvl = lvl_a[0];
        for (int i = 0; i < 20; i++) begin
            l_a[0] = ((i / 2) % 2 == 0);
            cyc();
            if (p_a[0] && !prev_p) pulses++;
            if (lvl_a[0] != prev_lvl) lvl_chg++;
            prev_p = p_a[0]; prev_lvl = lvl_a[0];
        end
        l_a[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (p_a[0] && !prev_p) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            if (lvl_a[0] != prev_lvl) lvl_chg++;
            prev_p = p_a[0]; prev_lvl = lvl_a[0];
        end
        check("t2_pulses", pulses, 1);
        check("t2_first_edge", first_k, 6);
        check("t2_lvl_changes", lvl_chg, 1);
        check("t2_lvl_final", {28'd0, lvl_a}, 32'h1);

        // 3: each MODE with a 10-cycle high on channel 1, PULSE_LEN=3
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            l_b[1] = 1'b1;
            pulses = 0; hi = 0; first_k = 0; prev_p = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                cyc();
                if (p_b[1]) hi++;
                if (p_b[1] && !prev_p) begin
                    pulses++;
                    if (first_k == 0) first_k = k;
                end
                prev_p = p_b[1];
                if (k == 10) l_b[1] = 1'b0;
            end
            check($sformatf("t3_m%0d_pulses", m), pulses, exp_pulses[m]);
            check($sformatf("t3_m%0d_hicycles", m), hi, exp_hi[m]);
            check($sformatf("t3_m%0d_first", m), first_k, exp_first[m]);
        end
        check("t3_lvl_end", {28'd0, lvl_b}, 32'h0);
        check("t3_busy_end", {28'd0, busy_b}, 32'h0);

        // 4: retrigger dropped during an 8-cycle pulse, then EN abort
        mode = 2'b10;
        l_c[2] = 1'b1;
        pulses = 0; hi = 0; first_k = 0; prev_p = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (p_c[2]) hi++;
            if (p_c[2] && !prev_p) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            prev_p = p_c[2];
            if (k == 4) l_c[2] = 1'b0;
        end
        check("t4_pulses", pulses, 1);
        check("t4_hicycles", hi, 8);
        check("t4_first", first_k, 3);
        check("t4_lvl_after", {28'd0, lvl_c}, 32'h0);
        l_c[2] = 1'b1;
        repeat (3) cyc();
        check("t4_p_start", {28'd0, p_c}, 32'h4);
        check("t4_busy_start", {28'd0, busy_c}, 32'h4);
        cyc();
        en = 1'b0;
        cyc();
        check("t4_p_en0", {28'd0, p_c}, 32'h0);
        check("t4_busy_en0", {28'd0, busy_c}, 32'h0);
        check("t4_lvl_en0", {28'd0, lvl_c}, 32'h4);
        l_c[2] = 1'b0;
        repeat (5) cyc();
        check("t4_lvl_track", {28'd0, lvl_c}, 32'h0);
        en = 1'b1;
        hi = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (p_c != 4'h0) hi++;
        end
        check("t4_lost_event", hi, 0);

        // 5: active-low inputs, channels 0 and 3 pressed together
        mode = 2'b00;
        l_d = 4'b0110;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 5) check("t5_p_e5", {28'd0, p_d}, 32'h0);
            if (k == 6) begin
                check("t5_p_e6", {28'd0, p_d}, 32'h9);
                check("t5_lvl_e6", {28'd0, lvl_d}, 32'h9);
                check("t5_busy_e6", {28'd0, busy_d}, 32'h9);
            end
            if (k == 7) check("t5_p_e7", {28'd0, p_d}, 32'h0);
        end

        // 6: asynchronous reset during the second cycle of a 5-cycle pulse
        l_e[0] = 1'b1;
        repeat (7) cyc();
        check("t6_p_cycle2", {28'd0, p_e}, 32'h1);
        check("t6_busy_cycle2", {28'd0, busy_e}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6_p_async", {28'd0, p_e}, 32'h0);
        check("t6_busy_async", {28'd0, busy_e}, 32'h0);
        check("t6_lvl_async", {28'd0, lvl_e}, 32'h0);
        #3 rst = 1'b0;
        // The aborted pulse must not resume; the held level is re-qualified
        // from idle 0 and so yields one fresh rise after the full latency.
        hi = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k <= 5 && p_e != 4'h0) hi++;
            if (k == 6) check("t6_p_fresh", {28'd0, p_e}, 32'h1);
        end
        check("t6_no_resume", hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
